// File: rtl/btn_debouncer_if.sv
// ----------------------------------------------------------------------
// btn_debouncer_if : raw button input and conditioned level/strobe outputs
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

interface btn_debouncer_if;
  logic btn_raw;
  logic btn_clean;
  logic btn_rise;
  logic btn_fall;
  logic busy;

  modport master (
    output btn_raw,
    input  btn_clean,
    input  btn_rise,
    input  btn_fall,
    input  busy
  );

  modport slave (
    input  btn_raw,
    output btn_clean,
    output btn_rise,
    output btn_fall,
    output busy
  );
endinterface

`default_nettype wire

// File: rtl/btn_debouncer.sv
// ----------------------------------------------------------------------
// btn_debouncer : synchroniser plus stability-counter qualification FSM
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module btn_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic             clk,
  input  logic             rst,
  btn_debouncer_if.slave   btn
);

  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_CHK_HIGH = 2'd1,
    S_HIGH     = 2'd2,
    S_CHK_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_w;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn.btn_raw};
    end
  end

  assign sync_w = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    // A bounce back to the stable level drops the candidate with no partial credit.
    case (state_q)
      S_LOW: begin
        if (sync_w) begin
          state_d = S_CHK_HIGH;
          cnt_d   = C_CNT_ONE;
        end
      end
      S_CHK_HIGH: begin
        if (!sync_w) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == C_CNT_MAX) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!sync_w) begin
          state_d = S_CHK_LOW;
          cnt_d   = C_CNT_ONE;
        end
      end
      S_CHK_LOW: begin
        if (sync_w) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == C_CNT_MAX) begin
          state_d = S_LOW;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state and registered, so they are glitch-free.
    clean_d = (state_d == S_HIGH) || (state_d == S_CHK_LOW);
    busy_d  = (state_d == S_CHK_HIGH) || (state_d == S_CHK_LOW);
  end

  assign btn.btn_clean = clean_q;
  assign btn.btn_rise  = rise_q;
  assign btn.btn_fall  = fall_q;
  assign btn.busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_btn_debouncer.sv
// ----------------------------------------------------------------------
// tb_btn_debouncer : table-driven bench, SYNC_STAGES=2, DEBOUNCE_CYCLES=4
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module tb_btn_debouncer;

  typedef struct {
    logic       rst;
    logic       raw;
    logic [3:0] exp; // {btn_clean, btn_rise, btn_fall, busy}
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  btn_debouncer_if bif();

  btn_debouncer #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .CNT_WIDTH       (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .btn (bif)
  );

  vec_t vecs[$];
  int   checks     = 0;
  int   errors     = 0;
  int   rise_cnt   = 0;
  int   fall_cnt   = 0;
  int   ped_cnt    = 0;
  int   overlap    = 0;
  logic prev_clean = 1'b0;

  task automatic add(input int n, input logic r, input logic raw, input logic [3:0] e);
    vec_t v;
    v.rst = r;
    v.raw = raw;
    v.exp = e;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  // Models a chained pos_edge_detector on btn_clean and tallies strobes.
  task automatic tally();
    if (bif.btn_rise && bif.btn_fall) overlap++;
    if (bif.btn_rise) rise_cnt++;
    if (bif.btn_fall) fall_cnt++;
    if (bif.btn_clean && !prev_clean) ped_cnt++;
    prev_clean = bif.btn_clean;
  endtask

  task automatic check_int(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic found;
    logic [3:0] got;

    rst         = 1'b0;
    bif.btn_raw = 1'b1;

    // Edge 0 is the edge just before the vector where raw (or rst) changes.
    // Reset held 3 cycles with raw high, then press accepted 7 edges after release.
    add(3, 1'b0, 1'b1, 4'b0000);
    add(2, 1'b1, 1'b1, 4'b0000);
    add(4, 1'b1, 1'b1, 4'b0001);
    add(1, 1'b1, 1'b1, 4'b1100);
    add(3, 1'b1, 1'b1, 4'b1000);
    // Two-cycle low glitch while high: busy pulses, level held, no fall.
    add(2, 1'b1, 1'b0, 4'b1000);
    add(2, 1'b1, 1'b1, 4'b1001);
    add(2, 1'b1, 1'b1, 4'b1000);
    // Clean release.
    add(2, 1'b1, 1'b0, 4'b1000);
    add(4, 1'b1, 1'b0, 4'b1001);
    add(1, 1'b1, 1'b0, 4'b0010);
    add(3, 1'b1, 1'b0, 4'b0000);
    // Bounce 1,0,1,0 then hold 1.
    add(1, 1'b1, 1'b1, 4'b0000);
    add(1, 1'b1, 1'b0, 4'b0000);
    add(1, 1'b1, 1'b1, 4'b0001);
    add(1, 1'b1, 1'b0, 4'b0000);
    add(1, 1'b1, 1'b1, 4'b0001);
    add(1, 1'b1, 1'b1, 4'b0000);
    add(4, 1'b1, 1'b1, 4'b0001);
    add(1, 1'b1, 1'b1, 4'b1100);
    add(2, 1'b1, 1'b1, 4'b1000);
    // Release again.
    add(2, 1'b1, 1'b0, 4'b1000);
    add(4, 1'b1, 1'b0, 4'b1001);
    add(1, 1'b1, 1'b0, 4'b0010);
    add(2, 1'b1, 1'b0, 4'b0000);
    // Press aborted by reset at edge 5, then full requalification.
    add(2, 1'b1, 1'b1, 4'b0000);
    add(2, 1'b1, 1'b1, 4'b0001);
    add(2, 1'b0, 1'b1, 4'b0000);
    add(2, 1'b1, 1'b1, 4'b0000);
    add(4, 1'b1, 1'b1, 4'b0001);
    add(1, 1'b1, 1'b1, 4'b1100);
    add(2, 1'b1, 1'b1, 4'b1000);

    foreach (vecs[i]) begin
      rst         = vecs[i].rst;
      bif.btn_raw = vecs[i].raw;
      @(posedge clk);
      #1;
      got = {bif.btn_clean, bif.btn_rise, bif.btn_fall, bif.busy};
      checks++;
      if (got !== vecs[i].exp) begin
        errors++;
        $display("FAIL vec%0d: got clean/rise/fall/busy=%b expected %b", i, got, vecs[i].exp);
      end
      tally();
    end

    // Release latency measured with a bounded wait for btn_fall.
    bif.btn_raw = 1'b0;
    lat   = -1;
    found = 1'b0;
    for (int c = 1; c <= 20 && !found; c++) begin
      @(posedge clk);
      #1;
      tally();
      if (bif.btn_fall === 1'b1) begin
        found = 1'b1;
        lat   = c;
      end
    end
    check_int("release_latency", lat, 7);
    check_int("release_clean_low", int'(bif.btn_clean), 0);
    @(posedge clk);
    #1;
    tally();
    check_int("fall_single_cycle", int'(bif.btn_fall), 0);

    check_int("rise_count", rise_cnt, 3);
    check_int("fall_count", fall_cnt, 3);
    check_int("pos_edge_pulses", ped_cnt, 3);
    check_int("rise_fall_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/btn_debouncer.md
Name: btn_debouncer

Overview:
Front-end conditioning stage for mechanical push-buttons and switches. It synchronises the raw asynchronous pad input into the clk domain and qualifies it through a stability counter. It drives a clean, glitch-free level into pos_edge_detector, which derives single-cycle press strobes from it. It also provides its own registered rise and fall strobes for consumers that need release events.

Parameters:
SYNC_STAGES, 2, number of flops in the input synchroniser chain (min 2).
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised cycles required to accept a new level (10 ms at 100 MHz; min 1).
CNT_WIDTH, 20, counter width; must satisfy DEBOUNCE_CYCLES <= 2^CNT_WIDTH - 1.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-low reset; sampled on rising clk edge, 0 = reset.
btn_raw  input  1  raw asynchronous button/switch input.
btn_clean  output  1  debounced level; feeds signal_in of pos_edge_detector.
btn_rise  output  1  one-cycle strobe when btn_clean goes 0->1.
btn_fall  output  1  one-cycle strobe when btn_clean goes 1->0.
busy  output  1  high while a candidate level change is being qualified.

Behaviour:
- Reset, when rst=0 at a clk edge: all synchroniser flops = 0, state = S_LOW, counter = 0. Outputs: btn_clean=0, btn_rise=0, btn_fall=0, busy=0. Reset asserted mid-qualification aborts it with no strobe. No output asserts during the reset cycle.
- Synchroniser: shift chain of SYNC_STAGES flops. sync = last stage. Only sync is used by the FSM.
- FSM states:
  S_LOW: btn_clean=0. If sync=1, go to S_CHK_HIGH and set counter=1.
  S_CHK_HIGH: btn_clean=0, busy=1.
    - sync=0: return to S_LOW, counter=0, no strobe.
    - sync=1 and counter==DEBOUNCE_CYCLES: go to S_HIGH, btn_clean=1, btn_rise=1 for exactly one cycle, counter=0.
    - Otherwise: counter+1.
  S_HIGH: btn_clean=1. If sync=0, go to S_CHK_LOW and set counter=1.
  S_CHK_LOW: btn_clean=1, busy=1. Mirror of S_CHK_HIGH with polarity inverted; success goes to S_LOW, btn_clean=0, btn_fall=1 for one cycle.
- Latency: raw level changes before edge 0 and stays stable. btn_clean changes at edge SYNC_STAGES+DEBOUNCE_CYCLES+1. Example: 2 stages, D=4 gives edge 7.
- btn_rise and btn_fall are registered and change on the same edge as btn_clean. Both are never high together. Minimum spacing between them is DEBOUNCE_CYCLES+1 cycles.
- Any bounce inside a qualification window restarts qualification from the stable state. There is no partial credit; the counter is cleared.
- Counter never wraps: its maximum value reached is DEBOUNCE_CYCLES.
- busy = 1 only in S_CHK_HIGH or S_CHK_LOW, and is driven from a registered state.
- DEBOUNCE_CYCLES=1: a level is accepted after 2 stable synchronised cycles (enter CHK, then accept).

Test Plan:
(All with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.)
1. Reset: hold rst=0 for 3 cycles with btn_raw=1 -> btn_clean/btn_rise/btn_fall/busy all 0 throughout. After release, btn_clean rises 7 edges later.
2. Clean press: btn_raw 0->1 before edge 0 and held -> busy=1 from edge 3. btn_clean=1 and btn_rise=1 at edge 7. btn_rise=0 at edge 8. btn_fall stays 0.
3. Bounce: btn_raw toggles 1,0,1,0 on successive cycles, then holds 1 -> no btn_rise during toggling. btn_clean rises exactly 7 edges after the final 0->1 transition.
4. Release glitch: with btn_clean=1, pulse btn_raw low for 2 cycles -> busy pulses, btn_clean stays 1, btn_fall never asserts.
5. Clean release: btn_raw 1->0 and held -> btn_clean=0 and btn_fall=1 at edge 7, single cycle. Chained pos_edge_detector emits exactly one pulse per accepted press across the full press/release sequence.
6. Reset mid-qualification: assert rst=0 at edge 5 of a press (busy=1) -> state S_LOW, counter 0, no btn_rise. After release, qualification restarts and takes the full 7 edges.
